// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with dead-time blanking,
// optional leading-zero suppression and a tear-free valid/ready value load.
module display_scan_ctrl #(
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] bin_in,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          frame_end_s, transfer_s, accept_s, lz_s;
  logic [3:0]    nib_s;

  // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0001100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      4'hF:    seg_decode = 7'b0111000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Scan sequencing: IDLE -> BLANK -> SHOW -> BLANK (next digit) ...
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Load port and frame-boundary transfer; accept and transfer are mutually exclusive
  always_comb begin
    frame_end_s  = (state_q == SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);
    transfer_s   = pend_valid_q && ((state_q == IDLE) || frame_end_s);
    accept_s     = load && !pend_valid_q;
    disp_d       = transfer_s ? pend_q : disp_q;
    pend_d       = accept_s ? bin_in : pend_q;
    if (transfer_s) begin
      pend_valid_d = 1'b0;
    end else if (accept_s) begin
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Moore output decode from registered state only
  always_comb begin
    case (idx_q)
      2'd0:    begin nib_s = disp_q[15:12]; lz_s = (disp_q[15:12] == 4'h0); end
      2'd1:    begin nib_s = disp_q[11:8];  lz_s = (disp_q[15:8]  == 8'h00); end
      2'd2:    begin nib_s = disp_q[7:4];   lz_s = (disp_q[15:4]  == 12'h000); end
      default: begin nib_s = disp_q[3:0];   lz_s = 1'b0; end
    endcase
    an  = 4'b1111;
    seg = 7'b1111111;
    if ((state_q == SHOW) && !(LZ_BLANK && lz_s)) begin
      an  = ~(4'b0001 << idx_q);
      seg = seg_decode(nib_s);
    end else begin
      an  = 4'b1111;
      seg = 7'b1111111;
    end
    digit_idx  = idx_q;
    frame_done = frame_end_s;
    ready      = ~pend_valid_q;
  end

endmodule
